// File: rtl/uart_periph.sv
// uart_periph: memory-mapped UART with a TX FIFO, a TX shifter, level interrupt
// and an optional receiver.
// Build option: define UART_RX_EN to include the receiver. Without it, RXD is
// ignored, RXDATA and STATUS[4:2] read 0, and RXIE is stored but never raises Intr.
// Register map (Addr[3:2]): 0 TXDATA (W), 1 RXDATA (R), 2 STATUS (R/W1C), 3 CTRL (R/W).
module uart_periph #(
   parameter logic [15:0] DIV_RESET = 16'd434,
   parameter int          TX_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        CS_N,
   input  logic        RD_N,
   input  logic        WR_N,
   input  logic [11:0] Addr,
   input  logic [31:0] DataIn,
   output logic [31:0] DataOut,
   output logic        Intr,
   output logic        TXD,
   input  logic        RXD
);

   localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(TX_DEPTH);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   // ---------------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------------
   logic sel_wr, sel_rd;
   logic wr_tx, wr_status, wr_ctrl;

   assign sel_wr    = !CS_N && !WR_N;
   assign sel_rd    = !CS_N && !RD_N && WR_N;
   assign wr_tx     = sel_wr && (Addr[3:2] == 2'd0);
   assign wr_status = sel_wr && (Addr[3:2] == 2'd2);
   assign wr_ctrl   = sel_wr && (Addr[3:2] == 2'd3);

   // Only Addr[3:2] and DataIn[17:0] carry meaning.
   logic unused_bus;
   assign unused_bus = ^{Addr[11:4], Addr[1:0], DataIn[31:18]};

   // ---------------------------------------------------------------------
   // Control register
   // ---------------------------------------------------------------------
   logic [15:0] div_q, div_d;
   logic        rxie_q, rxie_d;
   logic        txie_q, txie_d;

   // CTRL write: a divisor below 2 would leave no room for a mid-bit sample, so clamp it.
   always_comb begin
      div_d  = div_q;
      rxie_d = rxie_q;
      txie_d = txie_q;
      if (wr_ctrl) begin
         div_d  = (DataIn[15:0] < 16'd2) ? 16'd2 : DataIn[15:0];
         rxie_d = DataIn[16];
         txie_d = DataIn[17];
      end
   end

   // ---------------------------------------------------------------------
   // TX FIFO
   // ---------------------------------------------------------------------
   logic [7:0]    fifo_mem [TX_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          fifo_full, fifo_empty;
   logic          tx_push, tx_pop;

   assign fifo_full  = (count_q == FULL_CNT);
   assign fifo_empty = (count_q == '0);
   // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
   assign tx_push    = wr_tx && (!fifo_full || tx_pop);

   // Pointer and occupancy update; pointers wrap naturally (depth is a power of 2).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (tx_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (tx_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({tx_push, tx_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO storage has no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (tx_push) fifo_mem[wr_ptr_q] <= DataIn[7:0];
   end

   // ---------------------------------------------------------------------
   // TX FSM
   // ---------------------------------------------------------------------
   tx_state_t   tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [15:0] tx_div_q, tx_div_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        txd_q, txd_d;
   logic        tx_bit_end;

   // tx_div_q is re-latched at every bit start so a divisor change lands on a bit boundary.
   assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);

   // TX next state; TXD is registered from the next state so it changes on bit boundaries only.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + 16'd1;
      tx_div_d   = tx_div_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      txd_d      = txd_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            txd_d    = 1'b1;
            if (!fifo_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = fifo_mem[rd_ptr_q];
               tx_div_d   = div_q;
               tx_state_d = TX_START;
               txd_d      = 1'b0;
            end
         end
         TX_START: begin
            if (tx_bit_end) begin
               tx_cnt_d   = '0;
               tx_div_d   = div_q;
               tx_bit_d   = '0;
               tx_state_d = TX_DATA;
               txd_d      = tx_shift_q[0];
            end
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               tx_cnt_d = '0;
               tx_div_d = div_q;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TX_STOP;
                  txd_d      = 1'b1;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  txd_d      = tx_shift_q[1];
               end
            end
         end
         TX_STOP: begin
            if (tx_bit_end) begin
               tx_cnt_d = '0;
               tx_div_d = div_q;
               // Chain straight into the next frame when data is waiting.
               if (!fifo_empty) begin
                  tx_pop     = 1'b1;
                  tx_shift_d = fifo_mem[rd_ptr_q];
                  tx_state_d = TX_START;
                  txd_d      = 1'b0;
               end else begin
                  tx_state_d = TX_IDLE;
                  txd_d      = 1'b1;
               end
            end
         end
         default: begin
            tx_state_d = TX_IDLE;
            txd_d      = 1'b1;
         end
      endcase
   end

   assign TXD = txd_q;

   // ---------------------------------------------------------------------
   // TX status flags
   // ---------------------------------------------------------------------
   logic tx_ovr_q, tx_ovr_d;
   logic tx_empty;

   assign tx_empty = fifo_empty && (tx_state_q == TX_IDLE);

   // TXOVR: a dropped write sets it; W1C clears it; a set on the same edge wins.
   always_comb begin
      tx_ovr_d = (tx_ovr_q & ~(wr_status & DataIn[5])) | (wr_tx & fifo_full & ~tx_pop);
   end

   // Control, FIFO, TX and TX status registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q      <= DIV_RESET;
         rxie_q     <= 1'b0;
         txie_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_div_q   <= DIV_RESET;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         txd_q      <= 1'b1;
         tx_ovr_q   <= 1'b0;
      end else begin
         div_q      <= div_d;
         rxie_q     <= rxie_d;
         txie_q     <= txie_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_div_q   <= tx_div_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
         tx_ovr_q   <= tx_ovr_d;
      end
   end

   // ---------------------------------------------------------------------
   // Receiver
   // ---------------------------------------------------------------------
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ovr;
   logic       rx_ferr;

`ifdef UART_RX_EN
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   logic        rd_rx;
   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic        rx_prev_q, rx_prev_d;
   rx_state_t   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [15:0] rx_div_q, rx_div_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        rx_ovr_q, rx_ovr_d;
   logic        rx_ferr_q, rx_ferr_d;
   logic        rx_done, rx_stop_bad;

   assign rd_rx = sel_rd && (Addr[3:2] == 2'd1);

   // Two-flop synchroniser, edge history, and the RX bit-timing FSM.
   always_comb begin
      sync1_d     = RXD;
      sync2_d     = sync1_q;
      rx_prev_d   = sync2_q;
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q + 16'd1;
      rx_div_d    = rx_div_q;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      rx_done     = 1'b0;
      rx_stop_bad = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !sync2_q) begin
               rx_state_d = RX_START;
               rx_div_d   = div_q;
            end
         end
         RX_START: begin
            // Half a bit in: a line that is high again was a glitch.
            if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
               rx_cnt_d   = '0;
               rx_div_d   = div_q;
               rx_bit_d   = '0;
               rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == rx_div_q - 16'd1) begin
               rx_cnt_d   = '0;
               rx_div_d   = div_q;
               rx_shift_d = {sync2_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
               else                  rx_bit_d   = rx_bit_q + 3'd1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == rx_div_q - 16'd1) begin
               rx_cnt_d    = '0;
               rx_div_d    = div_q;
               rx_done     = 1'b1;
               rx_stop_bad = !sync2_q;
               rx_state_d  = RX_IDLE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Received-byte holding register and RX flags; sets win over W1C on the same edge.
   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      rx_ovr_d   = rx_ovr_q & ~(wr_status & DataIn[3]);
      rx_ferr_d  = rx_ferr_q & ~(wr_status & DataIn[4]);
      if (rx_done) begin
         if (rx_stop_bad) rx_ferr_d = 1'b1;
         if (rx_valid_q && !rd_rx) begin
            rx_ovr_d = 1'b1;
         end else begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
         end
      end else if (rd_rx) begin
         rx_valid_d = 1'b0;
      end
   end

   // Receiver registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_div_q   <= DIV_RESET;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_ovr_q   <= 1'b0;
         rx_ferr_q  <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         rx_prev_q  <= rx_prev_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_div_q   <= rx_div_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_ovr_q   <= rx_ovr_d;
         rx_ferr_q  <= rx_ferr_d;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign rx_ovr   = rx_ovr_q;
   assign rx_ferr  = rx_ferr_q;
`else
   assign rx_data  = 8'h00;
   assign rx_valid = 1'b0;
   assign rx_ovr   = 1'b0;
   assign rx_ferr  = 1'b0;

   logic unused_rx;
   assign unused_rx = ^{RXD, DataIn[4:3]};
`endif

   // ---------------------------------------------------------------------
   // Read mux and interrupt
   // ---------------------------------------------------------------------
   // Zero-latency read data; the bus sees 0 unless a read strobe is active.
   always_comb begin
      DataOut = 32'h0;
      if (!CS_N && !RD_N) begin
         case (Addr[3:2])
            2'd1:    DataOut = {24'h0, rx_data};
            2'd2:    DataOut = {26'h0, tx_ovr_q, rx_ferr, rx_ovr, rx_valid, tx_empty, fifo_full};
            2'd3:    DataOut = {14'h0, txie_q, rxie_q, div_q};
            default: DataOut = 32'h0;
         endcase
      end
   end

   assign Intr = (rxie_q & rx_valid) | (txie_q & tx_empty);

endmodule

// File: tb/tb_uart_periph.sv
// tb_uart_periph: register-table checks, serial TX frame scoreboard, FIFO
// overflow, reset abort and (with UART_RX_EN) receiver scenarios.
module tb_uart_periph;

   localparam logic [15:0] DIV_RST = 16'd434;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        CS_N = 1'b1;
   logic        RD_N = 1'b1;
   logic        WR_N = 1'b1;
   logic [11:0] Addr = '0;
   logic [31:0] DataIn = '0;
   logic [31:0] DataOut;
   logic        Intr;
   logic        TXD;
   logic        RXD = 1'b1;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int tb_div = 434;

   // Scoreboard of bytes expected on TXD, in order.
   logic [7:0] exp_q[$];

   uart_periph #(.DIV_RESET(DIV_RST), .TX_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .CS_N(CS_N), .RD_N(RD_N), .WR_N(WR_N),
      .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut), .Intr(Intr),
      .TXD(TXD), .RXD(RXD)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   // ---------------- TX serial monitor (samples on negedge) ----------------
   logic       mon_active = 1'b0;
   logic       mon_bad = 1'b0;
   logic       mon_unexp = 1'b0;
   logic [7:0] mon_exp = '0;
   logic [7:0] mon_got = '0;
   int         mon_cyc = 0;

   always @(negedge clk) begin
      if (!reset) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (TXD == 1'b0) begin
            mon_active = 1'b1;
            mon_cyc    = 1;
            mon_bad    = 1'b0;
            mon_got    = '0;
            if (exp_q.size() == 0) begin
               mon_unexp = 1'b1;
               mon_exp   = '0;
            end else begin
               mon_unexp = 1'b0;
               mon_exp   = exp_q.pop_front();
            end
         end
      end else begin
         int  bidx;
         logic lvl;
         bidx = mon_cyc / tb_div;
         if (bidx == 0)      lvl = 1'b0;
         else if (bidx == 9) lvl = 1'b1;
         else                lvl = mon_exp[bidx-1];
         if (TXD !== lvl) mon_bad = 1'b1;
         if (bidx >= 1 && bidx <= 8 && (mon_cyc % tb_div) == tb_div / 2) mon_got[bidx-1] = TXD;
         mon_cyc++;
         if (mon_cyc == 10 * tb_div) begin
            mon_active = 1'b0;
            tests_run++;
            if (mon_bad || mon_unexp) begin
               tests_failed++;
               $display("FAIL tx_frame: got byte 0x%02h (timing_err=%0b unexpected=%0b) required 0x%02h",
                        mon_got, mon_bad, mon_unexp, mon_exp);
            end else begin
               $display("ok   tx_frame: 0x%02h", mon_got);
            end
         end
      end
   end

   // ---------------- bus tasks: start and end on a negedge ----------------
   task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
      CS_N = 1'b0; WR_N = 1'b0; RD_N = 1'b1; Addr = a; DataIn = d;
      @(negedge clk);
      CS_N = 1'b1; WR_N = 1'b1;
      $display("wr   addr=0x%03h data=0x%08h", a, d);
   endtask

   task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
      CS_N = 1'b0; RD_N = 1'b0; WR_N = 1'b1; Addr = a;
      #1 d = DataOut;
      @(negedge clk);
      CS_N = 1'b1; RD_N = 1'b1;
   endtask

   task automatic read_check(input string name, input logic [11:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(a, d);
      check(name, d, exp);
   endtask

   task automatic wait_tx_done(input int max_cycles);
      int n = 0;
      while ((exp_q.size() != 0 || mon_active) && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      check("tx_drain", {31'h0, mon_active} + exp_q.size(), 32'h0);
      repeat (2) @(negedge clk);
   endtask

`ifdef UART_RX_EN
   task automatic rx_send(input logic [7:0] b, input logic stop_bit);
      RXD = 1'b0;
      repeat (tb_div) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RXD = b[i];
         repeat (tb_div) @(negedge clk);
      end
      RXD = stop_bit;
      repeat (tb_div) @(negedge clk);
      RXD = 1'b1;
      $display("rx   sent 0x%02h stop=%0b", b, stop_bit);
   endtask
`endif

   // ---------------- register vector table ----------------
   typedef struct {
      bit          wr;
      logic [11:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
      logic        exp_intr;
   } vec_t;

   vec_t vecs[14];

   initial begin
      logic [31:0] rd;
      int t0;
      int n;

      vecs[0]  = '{1'b0, 12'h00C, 32'h0,        {16'h0, DIV_RST}, 1'b0};
      vecs[1]  = '{1'b0, 12'h008, 32'h0,        32'h0000_0002,    1'b0};
      vecs[2]  = '{1'b0, 12'h000, 32'h0,        32'h0000_0000,    1'b0};
      vecs[3]  = '{1'b0, 12'h004, 32'h0,        32'h0000_0000,    1'b0};
      vecs[4]  = '{1'b1, 12'h00C, 32'h0003_0001, 32'h0,           1'b1};
      vecs[5]  = '{1'b0, 12'h00C, 32'h0,        32'h0003_0002,    1'b1};
      vecs[6]  = '{1'b1, 12'h00C, 32'h0000_0000, 32'h0,           1'b0};
      vecs[7]  = '{1'b0, 12'h00C, 32'h0,        32'h0000_0002,    1'b0};
      vecs[8]  = '{1'b1, 12'h008, 32'hFFFF_FFFF, 32'h0,           1'b0};
      vecs[9]  = '{1'b0, 12'h008, 32'h0,        32'h0000_0002,    1'b0};
      vecs[10] = '{1'b1, 12'h00C, 32'h0001_0004, 32'h0,           1'b0};
      vecs[11] = '{1'b0, 12'h00C, 32'h0,        32'h0001_0004,    1'b0};
      vecs[12] = '{1'b1, 12'h00C, 32'h0002_0004, 32'h0,           1'b1};
      vecs[13] = '{1'b0, 12'hFFC, 32'h0,        32'h0002_0004,    1'b1};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_txd", {31'h0, TXD}, 32'h1);
      check("rst_intr", {31'h0, Intr}, 32'h0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         if (vecs[i].wr) begin
            bus_write(vecs[i].addr, vecs[i].data);
         end else begin
            bus_read(vecs[i].addr, rd);
            check($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
         end
         check($sformatf("vec%0d_intr", i), {31'h0, Intr}, {31'h0, vecs[i].exp_intr});
      end

      // Read data gated by chip select and read strobe
      CS_N = 1'b1; RD_N = 1'b0; Addr = 12'h00C;
      #1 check("cs_off_dout", DataOut, 32'h0);
      CS_N = 1'b0; RD_N = 1'b1;
      #1 check("rd_off_dout", DataOut, 32'h0);
      CS_N = 1'b1;
      @(negedge clk);

      // Single frame 0xA5 at DIV=4
      tb_div = 4;
      exp_q.push_back(8'hA5);
      bus_write(12'h000, 32'h0000_00A5);
      check("a5_intr_busy", {31'h0, Intr}, 32'h0);
      wait_tx_done(200);
      read_check("a5_status", 12'h008, 32'h0000_0002);
      check("a5_intr_idle", {31'h0, Intr}, 32'h1);

      // Burst of five, then a sixth into a full FIFO
      for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i * 8'h11));
      bus_write(12'h000, 32'h11);
      t0 = cyc;
      bus_write(12'h000, 32'h22);
      bus_write(12'h000, 32'h33);
      bus_write(12'h000, 32'h44);
      bus_write(12'h000, 32'h55);
      bus_write(12'h000, 32'h66);
      read_check("burst_status_ovr", 12'h008, 32'h0000_0021);
      bus_write(12'h008, 32'h0000_0020);
      read_check("burst_status_clr", 12'h008, 32'h0000_0001);
      n = 0;
      while (Intr !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("burst_contiguous_len", cyc - t0, 32'd201);
      wait_tx_done(100);
      repeat (60) @(negedge clk);
      check("burst_no_extra", {31'h0, mon_active}, 32'h0);

`ifdef UART_RX_EN
      // Receiver scenarios at DIV=8 with RXIE
      bus_write(12'h00C, 32'h0001_0008);
      tb_div = 8;
      rx_send(8'h3C, 1'b1);
      repeat (4) @(negedge clk);
      read_check("rx_status_valid", 12'h008, 32'h0000_0006);
      check("rx_intr_set", {31'h0, Intr}, 32'h1);
      read_check("rx_data_3c", 12'h004, 32'h0000_003C);
      read_check("rx_status_clr", 12'h008, 32'h0000_0002);
      check("rx_intr_clr", {31'h0, Intr}, 32'h0);

      rx_send(8'h11, 1'b1);
      rx_send(8'h22, 1'b1);
      repeat (4) @(negedge clk);
      read_check("rx_status_ovr", 12'h008, 32'h0000_000E);
      read_check("rx_data_first", 12'h004, 32'h0000_0011);
      bus_write(12'h008, 32'h0000_0008);
      read_check("rx_ovr_clr", 12'h008, 32'h0000_0002);

      rx_send(8'h5A, 1'b0);
      repeat (4) @(negedge clk);
      read_check("rx_status_ferr", 12'h008, 32'h0000_0016);
      read_check("rx_data_ferr", 12'h004, 32'h0000_005A);
      bus_write(12'h008, 32'h0000_0010);
      read_check("rx_ferr_clr", 12'h008, 32'h0000_0002);

      rx_send(8'h77, 1'b1);
      repeat (4) @(negedge clk);
      RXD = 1'b0;
      repeat (2) @(negedge clk);
      RXD = 1'b1;
      repeat (120) @(negedge clk);
      read_check("rx_glitch_status", 12'h008, 32'h0000_0006);
      read_check("rx_glitch_data", 12'h004, 32'h0000_0077);

      bus_write(12'h00C, 32'h0002_0004);
      tb_div = 4;
`endif

      // Reset in the middle of a data bit (0xF0: data bits 0..3 are low)
      exp_q.push_back(8'hF0);
      bus_write(12'h000, 32'h0000_00F0);
      repeat (10) @(negedge clk);
      check("pre_rst_txd_low", {31'h0, TXD}, 32'h0);
      #2 reset = 1'b0;
      #1 check("rst_txd_async", {31'h0, TXD}, 32'h1);
      check("rst_intr_async", {31'h0, Intr}, 32'h0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      tb_div = 434;
      @(negedge clk);
      read_check("post_rst_status", 12'h008, 32'h0000_0002);
      read_check("post_rst_ctrl", 12'h00C, {16'h0, DIV_RST});
      repeat (20) @(negedge clk);
      check("post_rst_txd_idle", {31'h0, TXD}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/uart_periph.md
UART_PERIPH -- requirements
Module: uart_periph

Interface
REQ-001 SHALL have parameter DIV_RESET, default 16'd434, reset value of the baud divisor (clocks per bit).
REQ-002 SHALL have parameter TX_DEPTH, default 4, TX FIFO entries (power of 2, 2..16).
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port CS_N  input  1  chip select from the address decoder UART slot, active-low.
REQ-006 SHALL have port RD_N  input  1  read strobe, active-low.
REQ-007 SHALL have port WR_N  input  1  write strobe, active-low.
REQ-008 SHALL have port Addr  input  12  register offset; only Addr[3:2] decoded.
REQ-009 SHALL have port DataIn  input  32  CPU write data.
REQ-010 SHALL have port DataOut  output  32  register read data.
REQ-011 SHALL have port Intr  output  1  level interrupt, active-high.
REQ-012 SHALL have port TXD  output  1  serial out, idle high.
REQ-013 SHALL have port RXD  input  1  serial in, asynchronous to clk.

Function
REQ-014 SHALL map registers: 0x0 TXDATA (W), 0x4 RXDATA (R), 0x8 STATUS (R/W1C), 0xC CTRL (R/W).
REQ-015 SHALL drive DataOut combinationally (zero latency) from Addr[3:2] when CS_N=0 and RD_N=0, else 32'h0; unused bits read 0.
REQ-016 SHALL perform write side effects on the clock edge where CS_N=0, WR_N=0; read side effects where CS_N=0, RD_N=0, WR_N=1.
REQ-017 SHALL push DataIn[7:0] into the TX FIFO on a TXDATA write; if FIFO full, write dropped and STATUS.TXOVR set.
REQ-018 SHALL run the TX FSM IDLE->START->DATA->STOP->IDLE: START drives 0, DATA drives 8 bits LSB first, STOP drives 1, each exactly DIV clocks.
REQ-019 SHALL leave IDLE on the cycle after the FIFO becomes non-empty, popping one byte; from STOP go directly to START if FIFO non-empty (no idle gap).
REQ-020 SHALL accept a simultaneous push and pop when full (count unchanged, no TXOVR).
REQ-021 SHALL synchronise RXD with two flops; RX FSM IDLE->START->DATA->STOP: falling edge enters START, line re-sampled at DIV/2 (integer floor); high returns to IDLE (glitch rejected); data and stop sampled every DIV clocks thereafter.
REQ-022 SHALL load byte into RXDATA[7:0], set RXVALID at end of STOP; stop bit 0 sets FERR and still delivers the byte.
REQ-023 SHALL clear RXVALID on an RXDATA read; byte completing while RXVALID=1 and no same-edge read sets RXOVR and keeps old byte; same-edge read plus completion loads new byte, RXVALID stays 1, no RXOVR.
REQ-024 SHALL define STATUS: [0] TXFULL, [1] TXEMPTY (FIFO empty and TX FSM IDLE), [2] RXVALID, [3] RXOVR, [4] FERR, [5] TXOVR; writing 1 to bits 3..5 clears them, other bits ignore writes; set wins over same-edge clear.
REQ-025 SHALL define CTRL: [15:0] DIV, [16] RXIE, [17] TXIE; DIV written below 2 stored as 2; DIV change takes effect at next bit boundary.
REQ-026 SHALL drive Intr = (RXIE & RXVALID) | (TXIE & TXEMPTY), registered-free combinational.

Reset
REQ-027 SHALL, while reset=0: TXD=1, Intr=0, FIFO empty, both FSMs IDLE, RXDATA=0, all status flags 0, DIV=DIV_RESET, RXIE=TXIE=0, synchroniser flops=1.
REQ-028 SHALL abort any frame in progress on reset assertion; TXD returns high immediately (asynchronous).

Configuration
REQ-029 SHALL compile the receiver only when UART_RX_EN is defined; otherwise RXD unused, RXDATA reads 0, STATUS[2..4] read 0, RXIE stored but has no effect on Intr; TX behaviour identical either way.

Verification
REQ-030 SHALL test: DIV=4, write TXDATA=0xA5 -> TXD low 4 clk, then 1,0,1,0,0,1,0,1 each 4 clk, high 4 clk; TXEMPTY=1 after.
REQ-031 SHALL test: 5 back-to-back TXDATA writes (TX_DEPTH=4, TX idle) -> first pops immediately, all 5 accepted, TXOVR=0; sixth write while 4 queued -> TXOVR=1, byte lost, frames contiguous.
REQ-032 SHALL test (UART_RX_EN): DIV=8, drive 0x3C frame on RXD -> RXVALID=1, RXDATA=0x3C, Intr=1 with RXIE=1; RXDATA read -> RXVALID=0, Intr=0.
REQ-033 SHALL test: two RX frames without read -> RXOVR=1, RXDATA holds first byte; write STATUS=0x08 -> RXOVR=0.
REQ-034 SHALL test: RX frame with stop bit 0 -> FERR=1; 2-clk low glitch on RXD with DIV=8 -> no frame, RXVALID unchanged.
REQ-035 SHALL test: reset asserted mid-TX data bit -> TXD=1 same cycle, STATUS reads 0x02 after release, CTRL reads DIV_RESET.
